ldpc_msg_feeder: RTL and testbench
==================================

Name: ldpc_msg_feeder

Overview:
- Upstream stage of the LDPC encoder datapath.
- Accepts message words from a host over a valid/ready stream and serialises them LSB-first into the encoder's bit-serial input.
- Generates the encoder control strobes: a start pulse, a per-bit data enable, and the parity read request.
- Tracks frame completion and flags malformed frames.

Parameters:
- K, 32, message length in bits per codeword; must be a multiple of W.
- W, 8, host word width in bits.
- CW, $clog2(K+1), width of the message bit counter (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_data  in  W  host message word
- s_valid  in  1  s_data valid
- s_ready  out  1  feeder accepts s_data this cycle
- s_last  in  1  marks the final word of a frame
- en_start  out  1  one-cycle pulse; encoder loads generator state
- en_din  out  1  msg_bit valid this cycle
- msg_bit  out  1  serial message bit
- read_parity  out  1  one-cycle request to start parity readout
- parity_out_done  in  1  encoder finished parity readout
- done_encode  in  1  encoder idle in its encode state
- frame_done  out  1  one-cycle pulse at end of frame
- frame_err  out  1  sticky s_last mismatch flag
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset behaviour:
  - State goes to IDLE.
  - All outputs, including frame_err, go to 0.
  - Shift register and counters clear.
  - A reset mid-frame abandons the frame; no frame_done is generated.
- States: IDLE, START, LOAD, SHIFT, REQ, WAIT_P.
- IDLE:
  - s_ready=0.
  - On s_valid=1, go to START. The word is not consumed.
- START:
  - en_start=1 for exactly one cycle.
  - Clear the bit counter and frame_err, then go to LOAD.
- LOAD:
  - s_ready=1.
  - On handshake (s_valid and s_ready), capture s_data into the W-bit shift register.
  - Record s_last, then go to SHIFT.
  - Without a handshake, stay in LOAD with en_din=0. The encoder holds.
- SHIFT:
  - en_din=1 and msg_bit=shreg[0]; the register shifts right each cycle.
  - The bit counter increments each cycle.
  - After W bits:
    - If bit counter equals K, go to REQ.
    - Otherwise, go to LOAD.
- Early s_last: if the captured word had s_last=1 and bit counter < K after that word, set frame_err=1. Remaining bits are emitted as zeros (zero-padding) until the counter reaches K; the bubble rule still applies.
- Missing s_last: if the final word (bit counter reaches K) had s_last=0, set frame_err=1. The next host word starts a new frame.
- REQ:
  - en_din=0 and read_parity=1 for one cycle, then go to WAIT_P.
- WAIT_P:
  - All strobes low.
  - On parity_out_done=1, pulse frame_done for one cycle and go to IDLE.
  - parity_out_done is ignored in every other state.
- done_encode is monitoring only. If done_encode=0 in REQ, the fault is reported only under the optional feature; no state change.
- Timing (no prefetch): message phase is exactly K + K/W cycles with zero host stall. en_start precedes the first en_din by at least 2 cycles.
- en_din and read_parity are never high together. en_start is never high with either.

Optional Feature:
- Macro: LDPC_FEEDER_PREFETCH_EN.
- Defined:
  - Adds a second W-bit holding register; s_ready=1 during SHIFT while the holding register is empty.
  - The next word is moved into shreg on the last shift cycle, giving gapless en_din. Message phase is K cycles when the host never stalls.
  - Adds output feed_ovr, a sticky flag set if done_encode=0 in REQ.
- Undefined: single buffer, one LOAD bubble per word, no feed_ovr port.

Decomposition:
- Shared package ldpc_enc_pkg holds:
  - the state enum typedef;
  - the default K and W constants;
  - the counter width helper function.
- One natural sub-module, ldpc_bit_serializer. It contains the W-bit shift register, the per-word bit counter, load and shift controls, and a word_empty flag. The holding register under the macro lives here too.
- The FSM, frame counter and error flags stay in the top level.

Test Plan (K=32, W=8):
- Four words 0x01, 0x80, 0xFF, 0x00 with s_last on the 4th, host always valid, then parity_out_done 5 cycles after read_parity.
  - en_start occurs once and en_din is high 32 cycles in 4 groups of 8.
  - msg_bit sequence is 1,0000000 / 0000000,1 / 11111111 / 00000000.
  - read_parity occurs 1 cycle after the last bit; frame_done occurs the cycle after parity_out_done; frame_err=0.
- s_valid dropped for 3 cycles before word 3: LOAD holds, en_din=0 for 4 cycles total, bit order unchanged.
- s_last on word 2: frame_err=1, and bits 16-31 are zero with en_din=1.
- No s_last on word 4: frame_err=1 after the 32nd bit, and the 5th word begins a new frame with a new en_start and frame_err cleared.
- rst asserted mid-SHIFT at bit 13:
  - all outputs are 0 asynchronously and state is IDLE;
  - the next frame is correct from bit 0;
  - no frame_done is produced.
- With LDPC_FEEDER_PREFETCH_EN and host always valid: en_din is continuous for 32 cycles; with done_encode=0 at REQ, feed_ovr=1.

Source files
------------

// File: rtl/ldpc_enc_pkg.sv
// Shared types and defaults for the LDPC encoder front end: feeder FSM states,
// default code geometry and the counter width helper.
package ldpc_enc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_SHIFT,
    ST_REQ,
    ST_WAIT_P
  } feeder_state_e;

  localparam int DEF_K = 32;
  localparam int DEF_W = 8;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ldpc_bit_serializer.sv
// W-bit LSB-first serializer with per-word bit counter and s_last tag.
// With LDPC_FEEDER_PREFETCH_EN a one-word holding register feeds the shifter gaplessly.
module ldpc_bit_serializer
  import ldpc_enc_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] load_data_i,
  input  logic         load_last_i,
`ifdef LDPC_FEEDER_PREFETCH_EN
  input  logic         push_i,
  output logic         hold_full_o,
`endif
  output logic         bit_o,
  output logic         word_last_o,
  output logic         cur_last_o,
  output logic         word_empty_o
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(W - 1);

  logic [W-1:0]  shreg_q, shreg_d;
  logic          last_q, last_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic          empty_q, empty_d;
`ifdef LDPC_FEEDER_PREFETCH_EN
  logic [W-1:0]  hold_q, hold_d;
  logic          hold_last_q, hold_last_d;
  logic          hold_full_q, hold_full_d;
`endif

  // A load on the final shift cycle overrides the shift so the next word starts without a gap.
  always_comb begin
    shreg_d  = shreg_q;
    last_d   = last_q;
    bitcnt_d = bitcnt_q;
    empty_d  = empty_q;
`ifdef LDPC_FEEDER_PREFETCH_EN
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
`endif
    if (shift_i) begin
      shreg_d = shreg_q >> 1;
      if (bitcnt_q == LAST_IDX) begin
        bitcnt_d = '0;
        empty_d  = 1'b1;
      end else begin
        bitcnt_d = bitcnt_q + BW'(1);
      end
    end
    if (load_i) begin
`ifdef LDPC_FEEDER_PREFETCH_EN
      if (hold_full_q) begin
        shreg_d     = hold_q;
        last_d      = hold_last_q;
        hold_full_d = 1'b0;
      end else
`endif
      begin
        shreg_d = load_data_i;
        last_d  = load_last_i;
      end
      bitcnt_d = '0;
      empty_d  = 1'b0;
    end
`ifdef LDPC_FEEDER_PREFETCH_EN
    if (push_i) begin
      hold_d      = load_data_i;
      hold_last_d = load_last_i;
      hold_full_d = 1'b1;
    end
`endif
    if (clear_i) begin
      bitcnt_d = '0;
      empty_d  = 1'b1;
`ifdef LDPC_FEEDER_PREFETCH_EN
      hold_full_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q  <= '0;
      last_q   <= 1'b0;
      bitcnt_q <= '0;
      empty_q  <= 1'b1;
`ifdef LDPC_FEEDER_PREFETCH_EN
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      shreg_q  <= shreg_d;
      last_q   <= last_d;
      bitcnt_q <= bitcnt_d;
      empty_q  <= empty_d;
`ifdef LDPC_FEEDER_PREFETCH_EN
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  assign bit_o        = shreg_q[0];
  assign word_last_o  = (bitcnt_q == LAST_IDX);
  assign cur_last_o   = last_q;
  assign word_empty_o = empty_q;
`ifdef LDPC_FEEDER_PREFETCH_EN
  assign hold_full_o  = hold_full_q;
`endif

endmodule

// File: rtl/ldpc_msg_feeder.sv
// LDPC message feeder: host word stream to bit-serial encoder input plus control strobes.
// LDPC_FEEDER_PREFETCH_EN adds word prefetch (gapless en_din) and the feed_ovr flag.
module ldpc_msg_feeder
  import ldpc_enc_pkg::*;
#(
  parameter  int K  = DEF_K,
  parameter  int W  = DEF_W,
  localparam int CW = cnt_width(K)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_last,
  output logic         en_start,
  output logic         en_din,
  output logic         msg_bit,
  output logic         read_parity,
  input  logic         parity_out_done,
  input  logic         done_encode,
  output logic         frame_done,
  output logic         frame_err,
  output logic         busy
`ifdef LDPC_FEEDER_PREFETCH_EN
  ,
  output logic         feed_ovr
`endif
);

  localparam logic [CW-1:0] K_CNT     = CW'(K);
  localparam logic [CW-1:0] LAST_BASE = CW'(K - W);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          err_q, err_d;
  logic          pad_q, pad_d;
  logic          frame_done_q, frame_done_d;
  logic          pad_now;

  logic          ser_clear, ser_load, ser_shift, ser_load_last;
  logic [W-1:0]  ser_load_data;
  logic          ser_bit, ser_word_last, ser_cur_last, ser_empty;
`ifdef LDPC_FEEDER_PREFETCH_EN
  logic          ser_push, ser_hold_full;
  logic          ovr_q, ovr_d;
`else
  logic          unused_done_encode;
  assign unused_done_encode = done_encode;
`endif

  assign cnt_inc = cnt_q + CW'(1);
  // Once a frame ended early, every further word is synthesised as zeros tagged last.
  assign pad_now = pad_q | ((state_q == ST_SHIFT) & ser_cur_last);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    pad_d         = pad_q;
    frame_done_d  = 1'b0;
    s_ready       = 1'b0;
    en_start      = 1'b0;
    en_din        = 1'b0;
    read_parity   = 1'b0;
    ser_clear     = 1'b0;
    ser_load      = 1'b0;
    ser_shift     = 1'b0;
    ser_load_data = pad_now ? '0 : s_data;
    ser_load_last = pad_now | s_last;
`ifdef LDPC_FEEDER_PREFETCH_EN
    ser_push      = 1'b0;
    ovr_d         = ovr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (s_valid) state_d = ST_START;
      end
      ST_START: begin
        en_start  = 1'b1;
        cnt_d     = '0;
        err_d     = 1'b0;
        pad_d     = 1'b0;
        ser_clear = 1'b1;
`ifdef LDPC_FEEDER_PREFETCH_EN
        ovr_d     = 1'b0;
`endif
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        s_ready = ~pad_q;
        if (pad_q || s_valid) begin
          ser_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        en_din    = ~ser_empty;
        ser_shift = 1'b1;
        cnt_d     = cnt_inc;
`ifdef LDPC_FEEDER_PREFETCH_EN
        // Never prefetch past the final word so the next frame's first word waits for IDLE.
        s_ready = ~ser_hold_full & ~ser_cur_last & ~pad_q & (cnt_q < LAST_BASE);
        if (s_ready && s_valid && !ser_word_last) ser_push = 1'b1;
`endif
        if (ser_word_last) begin
          if (cnt_inc == K_CNT) begin
            state_d = ST_REQ;
            if (!ser_cur_last) err_d = 1'b1;
          end else begin
            if (ser_cur_last) begin
              err_d = 1'b1;
              pad_d = 1'b1;
            end
`ifdef LDPC_FEEDER_PREFETCH_EN
            if (ser_hold_full || pad_now || (s_ready && s_valid)) ser_load = 1'b1;
            else state_d = ST_LOAD;
`else
            state_d = ST_LOAD;
`endif
          end
        end
      end
      ST_REQ: begin
        read_parity = 1'b1;
`ifdef LDPC_FEEDER_PREFETCH_EN
        if (!done_encode) ovr_d = 1'b1;
`endif
        state_d = ST_WAIT_P;
      end
      ST_WAIT_P: begin
        if (parity_out_done) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      pad_q        <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef LDPC_FEEDER_PREFETCH_EN
      ovr_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      pad_q        <= pad_d;
      frame_done_q <= frame_done_d;
`ifdef LDPC_FEEDER_PREFETCH_EN
      ovr_q        <= ovr_d;
`endif
    end
  end

  ldpc_bit_serializer #(.W(W)) u_ser (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (ser_clear),
    .load_i       (ser_load),
    .shift_i      (ser_shift),
    .load_data_i  (ser_load_data),
    .load_last_i  (ser_load_last),
`ifdef LDPC_FEEDER_PREFETCH_EN
    .push_i       (ser_push),
    .hold_full_o  (ser_hold_full),
`endif
    .bit_o        (ser_bit),
    .word_last_o  (ser_word_last),
    .cur_last_o   (ser_cur_last),
    .word_empty_o (ser_empty)
  );

  assign msg_bit    = en_din & ser_bit;
  assign frame_done = frame_done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef LDPC_FEEDER_PREFETCH_EN
  assign feed_ovr   = ovr_q;
`endif

endmodule

// File: tb/tb_ldpc_msg_feeder.sv
// Directed self-checking bench for ldpc_msg_feeder (K=32, W=8).
// Under LDPC_FEEDER_PREFETCH_EN it runs the prefetch/feed_ovr scenario instead of the bubble-timing ones.
module tb_ldpc_msg_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid, s_ready, s_last;
  logic       en_start, en_din, msg_bit, read_parity;
  logic       parity_out_done, done_encode;
  logic       frame_done, frame_err, busy;
`ifdef LDPC_FEEDER_PREFETCH_EN
  logic       feed_ovr;
`endif

  always #5 clk = ~clk;

  ldpc_msg_feeder #(.K(32), .W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_last          (s_last),
    .en_start        (en_start),
    .en_din          (en_din),
    .msg_bit         (msg_bit),
    .read_parity     (read_parity),
    .parity_out_done (parity_out_done),
    .done_encode     (done_encode),
    .frame_done      (frame_done),
    .frame_err       (frame_err),
    .busy            (busy)
`ifdef LDPC_FEEDER_PREFETCH_EN
    ,
    .feed_ovr        (feed_ovr)
`endif
  );

  int testsRun, testsFailed;

  // Host scenario configuration
  logic [7:0] hostWords[16];
  logic       hostLast[16];
  int         nWords, stallIdx, stallCycles, resetAtBit, framesToRun;

  // Observations gathered by run_host
  logic capBits[$];
  int   groupLens[$];
  int   gapLens[$];
  logic errAtDone[$];
  logic errAtRp[$];
  int   enStartCount, rpCount, fdCount, hsCount, violations;
  int   startCycle, firstDinCycle, lastDinCycle, rpCycle, podCycle, fdCycle;
  bit   aborted;
  logic preResetDin, preResetBit, preResetBusy;
  logic [7:0] postResetOuts;

  function automatic logic [31:0] pack_bits(input int offset);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++)
      if (offset + i < capBits.size()) v[i] = capBits[offset + i];
    return v;
  endfunction

  function automatic logic [7:0] out_vec();
    return {en_start, en_din, msg_bit, read_parity, frame_done, frame_err, busy, s_ready};
  endfunction

  task automatic set_basic_words();
    hostWords[0] = 8'h01; hostWords[1] = 8'h80; hostWords[2] = 8'hFF; hostWords[3] = 8'h00;
    for (int i = 0; i < 16; i++) hostLast[i] = 1'b0;
    hostLast[3] = 1'b1;
    nWords = 4; stallIdx = -1; stallCycles = 0; resetAtBit = -1; framesToRun = 1;
  endtask

  // Cycle-by-cycle host and encoder model: inputs change on the falling edge, outputs sampled 1 time unit later.
  task automatic run_host(input int budget);
    int idx, stallLeft, cyc, curRun, podAt;
    logic prevDin;
    bit started;
    idx = 0; stallLeft = stallCycles; cyc = 0; curRun = 0; podAt = -1; prevDin = 1'b0; started = 0;
    capBits.delete(); groupLens.delete(); gapLens.delete(); errAtDone.delete(); errAtRp.delete();
    enStartCount = 0; rpCount = 0; fdCount = 0; hsCount = 0; violations = 0;
    startCycle = -1; firstDinCycle = -1; lastDinCycle = -1; rpCycle = -1; podCycle = -1; fdCycle = -1;
    aborted = 0;
    forever begin
      @(negedge clk);
      parity_out_done = (cyc == podAt);
      if (parity_out_done) podCycle = cyc;
      if (idx < nWords && !(idx == stallIdx && stallLeft > 0)) begin
        s_valid = 1'b1; s_data = hostWords[idx]; s_last = hostLast[idx];
      end else begin
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      end
      #1;
      if (resetAtBit >= 0 && en_din && capBits.size() == resetAtBit) begin
        preResetDin = en_din; preResetBit = msg_bit; preResetBusy = busy;
        rst = 1'b1;
        #1;
        postResetOuts = out_vec();
        aborted = 1;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; parity_out_done = 1'b0;
        return;
      end
      if (s_valid && s_ready) begin
        hsCount++;
        idx++;
      end else if (s_ready && idx == stallIdx && stallLeft > 0) begin
        stallLeft--;
      end
      if (en_start) begin enStartCount++; startCycle = cyc; end
      if (en_din) begin
        capBits.push_back(msg_bit);
        lastDinCycle = cyc;
        if (firstDinCycle < 0) firstDinCycle = cyc;
        if (!prevDin) begin
          if (started) gapLens.push_back(curRun);
          curRun = 1; started = 1;
        end else curRun++;
      end else begin
        if (prevDin) begin groupLens.push_back(curRun); curRun = 1; end
        else curRun++;
      end
      prevDin = en_din;
      if (read_parity) begin rpCount++; rpCycle = cyc; podAt = cyc + 5; errAtRp.push_back(frame_err); end
      if (frame_done) begin fdCount++; fdCycle = cyc; errAtDone.push_back(frame_err); end
      if ((en_din && read_parity) || (en_start && (en_din || read_parity))) violations++;
      if (fdCount == framesToRun) break;
      cyc++;
      if (cyc > budget) begin
        testsRun++; testsFailed++;
        $display("[TB] FAIL run_timeout: frame_done count %0d after %0d cycles, want %0d", fdCount, budget, framesToRun);
        break;
      end
    end
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; parity_out_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    testsRun++;
    if (out_vec() !== 8'h00) begin
      testsFailed++; $display("[TB] FAIL reset_outputs: got %b, want 00000000", out_vec());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    testsRun++;
    if (out_vec() !== 8'h00) begin
      testsFailed++; $display("[TB] FAIL idle_after_reset: got %b, want 00000000", out_vec());
    end
  endtask

  task automatic test_basic();
    set_basic_words();
    run_host(300);
    testsRun++;
    if (capBits.size() != 32) begin
      testsFailed++; $display("[TB] FAIL basic_din_count: got %0d, want 32", capBits.size());
    end
    testsRun++;
    if (pack_bits(0) !== 32'h00FF8001) begin
      testsFailed++; $display("[TB] FAIL basic_bits: got %h, want 00ff8001", pack_bits(0));
    end
    testsRun++;
    if (enStartCount != 1) begin
      testsFailed++; $display("[TB] FAIL basic_en_start: got %0d pulses, want 1", enStartCount);
    end
    testsRun++;
    if (!(groupLens.size() == 4 && groupLens[0] == 8 && groupLens[1] == 8 && groupLens[2] == 8 && groupLens[3] == 8)) begin
      testsFailed++; $display("[TB] FAIL basic_groups: got %0d groups, want 4 of 8", groupLens.size());
    end
    testsRun++;
    if (firstDinCycle - startCycle != 2) begin
      testsFailed++; $display("[TB] FAIL basic_start_lead: got %0d, want 2", firstDinCycle - startCycle);
    end
    testsRun++;
    if (lastDinCycle - startCycle != 36) begin
      testsFailed++; $display("[TB] FAIL basic_msg_phase: got %0d, want 36", lastDinCycle - startCycle);
    end
    testsRun++;
    if (rpCount != 1 || rpCycle != lastDinCycle + 1) begin
      testsFailed++; $display("[TB] FAIL basic_read_parity: got cycle %0d count %0d, want cycle %0d count 1", rpCycle, rpCount, lastDinCycle + 1);
    end
    testsRun++;
    if (fdCycle != podCycle + 1) begin
      testsFailed++; $display("[TB] FAIL basic_frame_done: got cycle %0d, want %0d", fdCycle, podCycle + 1);
    end
    testsRun++;
    if (errAtDone.size() != 1 || errAtDone[0] !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL basic_frame_err: got size %0d, want frame_err 0", errAtDone.size());
    end
    testsRun++;
    if (violations != 0) begin
      testsFailed++; $display("[TB] FAIL strobe_overlap: got %0d overlaps, want 0", violations);
    end
  endtask

  task automatic test_stall();
    set_basic_words();
    stallIdx = 2; stallCycles = 3;
    run_host(300);
    testsRun++;
    if (pack_bits(0) !== 32'h00FF8001 || capBits.size() != 32) begin
      testsFailed++; $display("[TB] FAIL stall_bits: got %h (%0d bits), want 00ff8001 (32)", pack_bits(0), capBits.size());
    end
    testsRun++;
    if (!(gapLens.size() == 3 && gapLens[0] == 1 && gapLens[1] == 4 && gapLens[2] == 1)) begin
      testsFailed++; $display("[TB] FAIL stall_gaps: got %0d gaps, want 1,4,1", gapLens.size());
    end
    testsRun++;
    if (lastDinCycle - startCycle != 39) begin
      testsFailed++; $display("[TB] FAIL stall_msg_phase: got %0d, want 39", lastDinCycle - startCycle);
    end
  endtask

  task automatic test_early_last();
    set_basic_words();
    hostLast[1] = 1'b1; hostLast[3] = 1'b0; nWords = 2;
    run_host(300);
    testsRun++;
    if (pack_bits(0) !== 32'h00008001 || capBits.size() != 32) begin
      testsFailed++; $display("[TB] FAIL early_bits: got %h (%0d bits), want 00008001 (32)", pack_bits(0), capBits.size());
    end
    testsRun++;
    if (errAtDone.size() != 1 || errAtDone[0] !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL early_frame_err: got size %0d, want frame_err 1", errAtDone.size());
    end
    testsRun++;
    if (hsCount != 2) begin
      testsFailed++; $display("[TB] FAIL early_handshakes: got %0d, want 2", hsCount);
    end
    testsRun++;
    if (lastDinCycle - startCycle != 36) begin
      testsFailed++; $display("[TB] FAIL early_msg_phase: got %0d, want 36", lastDinCycle - startCycle);
    end
  endtask

  task automatic test_missing_last();
    set_basic_words();
    hostWords[4] = 8'hA5; hostWords[5] = 8'h3C; hostWords[6] = 8'h0F; hostWords[7] = 8'hF0;
    hostLast[3] = 1'b0; hostLast[7] = 1'b1;
    nWords = 8; framesToRun = 2;
    run_host(400);
    testsRun++;
    if (enStartCount != 2) begin
      testsFailed++; $display("[TB] FAIL missing_en_start: got %0d pulses, want 2", enStartCount);
    end
    testsRun++;
    if (errAtRp.size() < 1 || errAtRp[0] !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL missing_err_after_bit32: got size %0d, want frame_err 1", errAtRp.size());
    end
    testsRun++;
    if (errAtDone.size() != 2 || errAtDone[0] !== 1'b1 || errAtDone[1] !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL missing_err_per_frame: got %0d frames, want err 1 then 0", errAtDone.size());
    end
    testsRun++;
    if (capBits.size() != 64 || pack_bits(0) !== 32'h00FF8001 || pack_bits(32) !== 32'hF00F3CA5) begin
      testsFailed++; $display("[TB] FAIL missing_bits: got %h %h (%0d bits), want 00ff8001 f00f3ca5 (64)", pack_bits(0), pack_bits(32), capBits.size());
    end
  endtask

  task automatic test_mid_reset();
    logic sawActivity;
    set_basic_words();
    for (int i = 0; i < 4; i++) hostWords[i] = 8'hFF;
    resetAtBit = 13;
    run_host(300);
    testsRun++;
    if (!aborted || preResetDin !== 1'b1 || preResetBit !== 1'b1 || preResetBusy !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL reset_reach_bit13: got din %b bit %b busy %b, want 111", preResetDin, preResetBit, preResetBusy);
    end
    testsRun++;
    if (postResetOuts !== 8'h00) begin
      testsFailed++; $display("[TB] FAIL reset_async_outputs: got %b, want 00000000", postResetOuts);
    end
    @(negedge clk);
    rst = 1'b0;
    sawActivity = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (frame_done || busy) sawActivity = 1'b1;
    end
    testsRun++;
    if (sawActivity !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_no_frame_done: got activity %b, want 0", sawActivity);
    end
    set_basic_words();
    run_host(300);
    testsRun++;
    if (pack_bits(0) !== 32'h00FF8001 || capBits.size() != 32 || enStartCount != 1) begin
      testsFailed++; $display("[TB] FAIL reset_next_frame: got %h (%0d bits, %0d starts), want 00ff8001 (32, 1)", pack_bits(0), capBits.size(), enStartCount);
    end
  endtask

`ifdef LDPC_FEEDER_PREFETCH_EN
  task automatic test_prefetch();
    set_basic_words();
    done_encode = 1'b0;
    run_host(300);
    testsRun++;
    if (!(groupLens.size() == 1 && groupLens[0] == 32)) begin
      testsFailed++; $display("[TB] FAIL prefetch_continuous: got %0d groups, want 1 of 32", groupLens.size());
    end
    testsRun++;
    if (pack_bits(0) !== 32'h00FF8001) begin
      testsFailed++; $display("[TB] FAIL prefetch_bits: got %h, want 00ff8001", pack_bits(0));
    end
    testsRun++;
    if (rpCycle != lastDinCycle + 1) begin
      testsFailed++; $display("[TB] FAIL prefetch_read_parity: got %0d, want %0d", rpCycle, lastDinCycle + 1);
    end
    testsRun++;
    if (feed_ovr !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL prefetch_feed_ovr: got %b, want 1", feed_ovr);
    end
    done_encode = 1'b1;
  endtask
`endif

  initial begin
    testsRun = 0; testsFailed = 0;
    rst = 1'b1;
    s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    parity_out_done = 1'b0; done_encode = 1'b1;
    nWords = 0; stallIdx = -1; stallCycles = 0; resetAtBit = -1; framesToRun = 1;
    test_reset();
`ifdef LDPC_FEEDER_PREFETCH_EN
    test_prefetch();
`else
    test_basic();
    test_stall();
    test_early_last();
    test_missing_last();
    test_mid_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
